// File: rtl/catch_judge_pkg.sv
// Shared encodings, screen geometry and the box-overlap helper for the catch/miss judge.
package catch_judge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_PLAY   = 2'b01,
    ST_FREEZE = 2'b10,
    ST_OVER   = 2'b11
  } state_t;

  localparam int SCR_W          = 640;
  localparam int SCR_H          = 480;
  localparam int COORD_W        = $clog2(SCR_W) + 2;
  localparam int CMP_W          = COORD_W + 1;
  localparam int DEF_OBJ_W      = 40;
  localparam int DEF_OBJ_FLOOR  = SCR_H - DEF_OBJ_W;
  localparam int DEF_PLY_W      = 80;
  localparam int DEF_PLY_H      = 20;
  localparam int DEF_LIVES_INIT = 3;

  // One extra bit on every operand so edge + length can never wrap.
  function automatic logic spans_overlap(input logic [CMP_W-1:0] a0,
                                         input logic [CMP_W-1:0] a_len,
                                         input logic [CMP_W-1:0] b0,
                                         input logic [CMP_W-1:0] b_len);
    return (a0 < b0 + b_len) && (b0 < a0 + a_len);
  endfunction

endpackage

// File: rtl/catch_judge_if.sv
// Signal bundle between the object/paddle sources, the judge and the VGA overlay.
interface catch_judge_if;
  import catch_judge_pkg::*;

  logic               start;
  logic [COORD_W-1:0] obj_x;
  logic [COORD_W-1:0] obj_y;
  logic               end_show;
  logic [COORD_W-1:0] player_x;
  logic [COORD_W-1:0] player_y;
  logic               freeze;
  logic               hit;
  logic               miss;
  logic [15:0]        score_bcd;
  logic [1:0]         lives;
  logic [1:0]         state;
  logic               won;

  modport master (
    output start, obj_x, obj_y, end_show, player_x, player_y,
    input  freeze, hit, miss, score_bcd, lives, state, won
  );

  modport slave (
    input  start, obj_x, obj_y, end_show, player_x, player_y,
    output freeze, hit, miss, score_bcd, lives, state, won
  );
endinterface

// File: rtl/catch_judge_bcd_cnt4.sv
// Four-digit BCD score counter: synchronous clear, +1 on inc, sticks at 9999.
module catch_judge_bcd_cnt4 (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] bcd
);

  logic [15:0] r_bcd;

  function automatic logic [15:0] bcd_sat_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v == 16'h9999) return v;
    for (int d = 0; d < 4; d++) begin
      if (carry) begin
        if (r[4*d +: 4] == 4'd9) begin
          r[4*d +: 4] = 4'd0;
        end else begin
          r[4*d +: 4] = r[4*d +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcd <= '0;
    end else if (clr) begin
      r_bcd <= '0;
    end else if (inc) begin
      r_bcd <= bcd_sat_inc(r_bcd);
    end
  end

  assign bcd = r_bcd;

endmodule

// File: rtl/catch_judge.sv
// Game-rule stage: detects catches and misses of the falling object, keeps score/lives
// and runs the IDLE/PLAY/FREEZE/OVER game flow; freeze holds the object source.
module catch_judge
  import catch_judge_pkg::*;
#(
  parameter int OBJ_W      = DEF_OBJ_W,
  parameter int PLY_W      = DEF_PLY_W,
  parameter int PLY_H      = DEF_PLY_H,
  parameter int OBJ_FLOOR  = DEF_OBJ_FLOOR,
  parameter int LIVES_INIT = DEF_LIVES_INIT,
  parameter int FREEZE_CYC = 25000000
) (
  input  logic          clk,
  input  logic          rst,
  catch_judge_if.slave  bus
);

  localparam int               CNT_W    = (FREEZE_CYC > 1) ? $clog2(FREEZE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FREEZE_CYC - 1);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_frz_cnt, w_frz_cnt_nxt;
  logic [1:0]         r_lives, w_lives_nxt;
  logic               r_won, w_won_nxt;
  logic               r_hit, w_hit_nxt;
  logic               r_miss, w_miss_nxt;
  logic               r_caught, w_caught_nxt;
  logic               r_ov_q;
  logic               r_start_q;
  logic [COORD_W-1:0] r_prev_y;

  logic        w_overlap;
  logic        w_wrap;
  logic        w_catch;
  logic        w_start_rise;
  logic        w_score_clr;
  logic        w_score_inc;
  logic [15:0] w_score_bcd;

  assign w_overlap = spans_overlap({1'b0, bus.obj_x}, CMP_W'(OBJ_W),
                                   {1'b0, bus.player_x}, CMP_W'(PLY_W))
                  && spans_overlap({1'b0, bus.obj_y}, CMP_W'(OBJ_W),
                                   {1'b0, bus.player_y}, CMP_W'(PLY_H));

  assign w_wrap       = (r_prev_y == COORD_W'(OBJ_FLOOR)) && (bus.obj_y == '0);
  assign w_start_rise = bus.start && !r_start_q;

  // A caught flag still set at the wrap belongs to the previous object, so it must
  // not mask an overlap that starts on the very cycle the new object appears.
  assign w_catch = (r_state == ST_PLAY) && w_overlap && !r_ov_q && !(r_caught && !w_wrap);

  always_comb begin
    w_state_nxt   = r_state;
    w_frz_cnt_nxt = r_frz_cnt;
    w_lives_nxt   = r_lives;
    w_won_nxt     = r_won;
    w_hit_nxt     = 1'b0;
    w_miss_nxt    = 1'b0;
    w_score_clr   = 1'b0;
    w_score_inc   = 1'b0;
    w_caught_nxt  = r_caught;

    if (w_catch) begin
      w_caught_nxt = 1'b1;
    end else if (w_wrap) begin
      w_caught_nxt = 1'b0;
    end

    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt  = ST_PLAY;
          w_score_clr  = 1'b1;
          w_lives_nxt  = 2'(LIVES_INIT);
          w_won_nxt    = 1'b0;
          w_caught_nxt = 1'b0;
        end
      end
      ST_PLAY: begin
        if (w_catch) begin
          w_hit_nxt     = 1'b1;
          w_score_inc   = 1'b1;
          w_frz_cnt_nxt = CNT_LOAD;
          w_state_nxt   = ST_FREEZE;
        end
        // end of sequence outranks a miss; a same-cycle catch has still scored above
        if (bus.end_show) begin
          w_state_nxt = ST_OVER;
          w_won_nxt   = (r_lives != 2'd0);
        end else if (w_wrap && !r_caught && !w_catch) begin
          w_miss_nxt = 1'b1;
          if (r_lives != 2'd0) w_lives_nxt = r_lives - 2'd1;
          if (r_lives <= 2'd1) begin
            w_state_nxt = ST_OVER;
            w_won_nxt   = 1'b0;
          end
        end
      end
      ST_FREEZE: begin
        if (bus.end_show) begin
          w_state_nxt = ST_OVER;
          w_won_nxt   = 1'b1;
        end else if (r_frz_cnt == '0) begin
          w_state_nxt = ST_PLAY;
        end else begin
          w_frz_cnt_nxt = r_frz_cnt - CNT_W'(1);
        end
      end
      ST_OVER: begin
        if (w_start_rise) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_frz_cnt <= '0;
      r_lives   <= 2'(LIVES_INIT);
      r_won     <= 1'b0;
      r_hit     <= 1'b0;
      r_miss    <= 1'b0;
      r_caught  <= 1'b0;
      r_ov_q    <= 1'b0;
      r_start_q <= 1'b0;
      r_prev_y  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_frz_cnt <= w_frz_cnt_nxt;
      r_lives   <= w_lives_nxt;
      r_won     <= w_won_nxt;
      r_hit     <= w_hit_nxt;
      r_miss    <= w_miss_nxt;
      r_caught  <= w_caught_nxt;
      r_ov_q    <= w_overlap;
      r_start_q <= bus.start;
      r_prev_y  <= bus.obj_y;
    end
  end

  catch_judge_bcd_cnt4 u_score (
    .clk (clk),
    .rst (rst),
    .clr (w_score_clr),
    .inc (w_score_inc),
    .bcd (w_score_bcd)
  );

  assign bus.freeze    = (r_state != ST_PLAY);
  assign bus.hit       = r_hit;
  assign bus.miss      = r_miss;
  assign bus.score_bcd = w_score_bcd;
  assign bus.lives     = r_lives;
  assign bus.state     = r_state;
  assign bus.won       = r_won;

endmodule

// File: tb/tb_catch_judge.sv
// Self-checking bench for catch_judge: geometry vector table plus game sequences,
// each cycle scored against a behavioural game model through an expectation queue.
module tb_catch_judge;

  localparam int OBJ_W      = 40;
  localparam int PLY_W      = 80;
  localparam int PLY_H      = 20;
  localparam int OBJ_FLOOR  = 440;
  localparam int LIVES_INIT = 3;
  localparam int FREEZE_CYC = 4;

  logic clk;
  logic rst;

  catch_judge_if bus ();

  catch_judge #(.FREEZE_CYC(FREEZE_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  state;
    logic        freeze;
    logic        hit;
    logic        miss;
    logic [15:0] score;
    logic [1:0]  lives;
    logic        won;
  } exp_t;

  typedef struct {
    int px;
    int py;
    int ox;
    int oy;
    bit exp_hit;
  } geo_t;

  exp_t sb[$];
  int   n_tests;
  int   n_fail;

  // behavioural game model
  int m_state, m_cnt, m_lives, m_score, m_prevy;
  bit m_won, m_hit, m_miss, m_caught, m_ovq, m_startq;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_lives = LIVES_INIT; m_score = 0; m_prevy = 0;
    m_won = 0; m_hit = 0; m_miss = 0; m_caught = 0; m_ovq = 0; m_startq = 0;
  endtask

  task automatic model_step();
    int ox, oy, px, py;
    bit ov, wrap, cat, st, es, n_caught;
    exp_t e;
    ox = bus.obj_x; oy = bus.obj_y; px = bus.player_x; py = bus.player_y;
    st = bus.start; es = bus.end_show;
    ov   = (ox < px + PLY_W) && (px < ox + OBJ_W) && (oy < py + PLY_H) && (py < oy + OBJ_W);
    wrap = (m_prevy == OBJ_FLOOR) && (oy == 0);
    cat  = (m_state == 1) && ov && !m_ovq && (!m_caught || wrap);
    if (m_state == 0 && st)  n_caught = 0;
    else if (cat)            n_caught = 1;
    else if (wrap)           n_caught = 0;
    else                     n_caught = m_caught;
    m_hit = 0; m_miss = 0;
    case (m_state)
      0: if (st) begin m_state = 1; m_score = 0; m_lives = LIVES_INIT; m_won = 0; end
      1: begin
        if (cat) begin
          m_hit = 1;
          if (m_score < 9999) m_score++;
          m_cnt = FREEZE_CYC - 1;
          m_state = 2;
        end
        if (es) begin
          m_state = 3; m_won = (m_lives > 0);
        end else if (wrap && !m_caught && !cat) begin
          m_miss = 1; m_lives--;
          if (m_lives == 0) begin m_state = 3; m_won = 0; end
        end
      end
      2: begin
        if (es) begin m_state = 3; m_won = 1; end
        else if (m_cnt == 0) m_state = 1;
        else m_cnt--;
      end
      default: if (st && !m_startq) m_state = 0;
    endcase
    m_caught = n_caught; m_ovq = ov; m_prevy = oy; m_startq = st;
    e.state = 2'(m_state); e.freeze = (m_state != 1); e.hit = m_hit; e.miss = m_miss;
    e.score = to_bcd(m_score); e.lives = 2'(m_lives); e.won = m_won;
    sb.push_back(e);
  endtask

  task automatic tick(input bit chk);
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (chk) begin
      check("state", 16'(bus.state), 16'(e.state));
      check("freeze", 16'(bus.freeze), 16'(e.freeze));
      check("hit", 16'(bus.hit), 16'(e.hit));
      check("miss", 16'(bus.miss), 16'(e.miss));
      check("score", bus.score_bcd, e.score);
      check("lives", 16'(bus.lives), 16'(e.lives));
      check("won", 16'(bus.won), 16'(e.won));
    end
  endtask

  task automatic set_pos(input int px, input int py, input int ox, input int oy);
    bus.player_x = 12'(px); bus.player_y = 12'(py);
    bus.obj_x = 12'(ox);    bus.obj_y = 12'(oy);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.end_show = 1'b0;
    set_pos(0, 0, 2000, 2000);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    sb.delete();
  endtask

  task automatic start_game();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  geo_t geo[12];

  initial begin
    int y, hits, misses, frz, hit_y;
    n_tests = 0;
    n_fail  = 0;
    geo[0]  = '{px: 300,  py: 440,  ox: 300,  oy: 400,  exp_hit: 0};
    geo[1]  = '{px: 300,  py: 440,  ox: 300,  oy: 401,  exp_hit: 1};
    geo[2]  = '{px: 300,  py: 440,  ox: 380,  oy: 420,  exp_hit: 0};
    geo[3]  = '{px: 300,  py: 440,  ox: 379,  oy: 420,  exp_hit: 1};
    geo[4]  = '{px: 300,  py: 440,  ox: 260,  oy: 420,  exp_hit: 0};
    geo[5]  = '{px: 300,  py: 440,  ox: 261,  oy: 420,  exp_hit: 1};
    geo[6]  = '{px: 300,  py: 440,  ox: 300,  oy: 460,  exp_hit: 0};
    geo[7]  = '{px: 300,  py: 440,  ox: 300,  oy: 459,  exp_hit: 1};
    geo[8]  = '{px: 4050, py: 100,  ox: 4080, oy: 100,  exp_hit: 1};
    geo[9]  = '{px: 100,  py: 4080, ox: 100,  oy: 4090, exp_hit: 1};
    geo[10] = '{px: 0,    py: 0,    ox: 0,    oy: 0,    exp_hit: 1};
    geo[11] = '{px: 4000, py: 0,    ox: 0,    oy: 0,    exp_hit: 0};

    // reset values while rst is held
    rst = 1'b1;
    bus.start = 1'b0; bus.end_show = 1'b0;
    set_pos(0, 0, 2000, 2000);
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 16'(bus.state), 16'd0);
    check("rst_freeze", 16'(bus.freeze), 16'd1);
    check("rst_hit", 16'(bus.hit), 16'd0);
    check("rst_miss", 16'(bus.miss), 16'd0);
    check("rst_score", bus.score_bcd, 16'h0000);
    check("rst_lives", 16'(bus.lives), 16'd3);
    check("rst_won", 16'(bus.won), 16'd0);

    do_reset();
    start_game();
    check("start_state", 16'(bus.state), 16'd1);
    check("start_freeze", 16'(bus.freeze), 16'd0);
    check("start_lives", 16'(bus.lives), 16'd3);
    check("start_score", bus.score_bcd, 16'h0000);

    for (int i = 0; i < 12; i++) begin
      do_reset();
      start_game();
      set_pos(geo[i].px, geo[i].py, geo[i].ox, geo[i].oy);
      tick(1);
      check($sformatf("geo%0d_hit", i), 16'(bus.hit), 16'(geo[i].exp_hit));
    end

    // object sweeps down onto a paddle at the floor
    do_reset();
    set_pos(300, 440, 300, 0);
    start_game();
    y = 0; hits = 0; misses = 0; frz = 0; hit_y = -1;
    for (int i = 0; i < 480; i++) begin
      bus.obj_y = 12'(y);
      tick(1);
      if (bus.hit)    begin hits++; hit_y = y; end
      if (bus.miss)   misses++;
      if (bus.freeze) frz++;
      if (m_state == 1) y = (y == OBJ_FLOOR) ? 0 : y + 1;
    end
    check("sweep_hits", 16'(hits), 16'd1);
    check("sweep_hit_y", 16'(hit_y), 16'(440 - OBJ_W + 1));
    check("sweep_miss", 16'(misses), 16'd0);
    check("sweep_freeze_cyc", 16'(frz), 16'd4);
    check("sweep_state", 16'(bus.state), 16'd1);
    check("sweep_score", bus.score_bcd, 16'h0001);

    // three uncaught objects end the game
    do_reset();
    set_pos(0, 440, 500, 0);
    start_game();
    y = 0; hits = 0; misses = 0;
    for (int i = 0; i < 1400; i++) begin
      bus.obj_y = 12'(y);
      tick(1);
      if (bus.hit)  hits++;
      if (bus.miss) misses++;
      if (m_state == 1) y = (y == OBJ_FLOOR) ? 0 : y + 1;
    end
    check("miss_count", 16'(misses), 16'd3);
    check("miss_hits", 16'(hits), 16'd0);
    check("miss_state", 16'(bus.state), 16'd3);
    check("miss_lives", 16'(bus.lives), 16'd0);
    check("miss_won", 16'(bus.won), 16'd0);

    // overlap begins on the wrap cycle
    do_reset();
    set_pos(300, 0, 300, 440);
    start_game();
    tick(1);
    bus.obj_y = 12'd0;
    tick(1);
    check("wrapcatch_hit", 16'(bus.hit), 16'd1);
    check("wrapcatch_miss", 16'(bus.miss), 16'd0);
    check("wrapcatch_lives", 16'(bus.lives), 16'd3);

    // end_show in FREEZE, then held/re-pressed start
    do_reset();
    set_pos(0, 0, 500, 440);
    start_game();
    tick(1);
    bus.obj_y = 12'd0;
    tick(1);
    check("es_miss", 16'(bus.miss), 16'd1);
    check("es_lives", 16'(bus.lives), 16'd2);
    set_pos(300, 0, 300, 200);
    tick(1);
    bus.obj_y = 12'd0;
    tick(1);
    check("es_hit", 16'(bus.hit), 16'd1);
    check("es_frz_state", 16'(bus.state), 16'd2);
    bus.end_show = 1'b1;
    bus.start = 1'b1;
    tick(1);
    bus.end_show = 1'b0;
    check("es_over", 16'(bus.state), 16'd3);
    check("es_won", 16'(bus.won), 16'd1);
    repeat (3) tick(1);
    check("es_held_start", 16'(bus.state), 16'd3);
    bus.start = 1'b0;
    tick(1);
    check("es_released", 16'(bus.state), 16'd3);
    bus.start = 1'b1;
    tick(1);
    check("es_to_idle", 16'(bus.state), 16'd0);
    tick(1);
    check("es_to_play", 16'(bus.state), 16'd1);
    bus.start = 1'b0;

    // score saturation: 9999 catches on wrap, then one more
    do_reset();
    set_pos(300, 0, 300, 440);
    start_game();
    for (int n = 0; n < 9999; n++) begin
      bus.obj_y = 12'd0;
      repeat (4) tick(0);
      bus.obj_y = 12'(OBJ_FLOOR);
      tick(0);
    end
    check("sat_preload", bus.score_bcd, 16'h9999);
    check("sat_preload_state", 16'(bus.state), 16'd1);
    bus.obj_y = 12'd0;
    tick(1);
    check("sat_hit", 16'(bus.hit), 16'd1);
    check("sat_score", bus.score_bcd, 16'h9999);

    // asynchronous reset in the middle of a game
    #2;
    rst = 1'b1;
    #1;
    check("async_state", 16'(bus.state), 16'd0);
    check("async_freeze", 16'(bus.freeze), 16'd1);
    check("async_score", bus.score_bcd, 16'h0000);
    check("async_lives", 16'(bus.lives), 16'd3);
    check("async_hit", 16'(bus.hit), 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
